// File: rtl/t5_dbrg.sv
// t5_dbrg: data-side bridge from the core strobe to a request/grant/response memory port.
// One outstanding transaction; a watchdog turns unanswered accesses into an error ack.
module t5_dbrg #(
  parameter int TOUT = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  input  logic [3:0]  dwb_sel,
  input  logic [31:2] dwb_adr,
  input  logic [31:0] dwb_dto,
  output logic        dwb_ack,
  output logic [31:0] dwb_dti,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:2] mem_adr,
  output logic [31:0] mem_wdat,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdat,
  output logic        err_stb,
  output logic [31:2] err_adr,
  output logic [7:0]  err_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;
  state_t state;
  logic [15:0] wdog;
  logic done;
  logic tmo;
  // a completion in the last watchdog cycle beats the timeout
  assign done = (state == REQ && mem_gnt && mem_we) || (state == WAIT && mem_rvalid);
  assign tmo = (state == REQ || state == WAIT) && wdog == 16'(TOUT - 1) && !done;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      wdog     <= '0;
      dwb_ack  <= 1'b0;
      dwb_dti  <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= '0;
      mem_adr  <= '0;
      mem_wdat <= '0;
      err_stb  <= 1'b0;
      err_adr  <= '0;
      err_cnt  <= '0;
    end else begin
      dwb_ack <= 1'b0;
      err_stb <= 1'b0;
      if (tmo) begin
        state   <= ACK;
        mem_req <= 1'b0;
        dwb_ack <= 1'b1;
        dwb_dti <= '0;
        err_stb <= 1'b1;
        err_adr <= mem_adr;
        err_cnt <= err_cnt + {7'd0, ~&err_cnt};
      end else begin
        case (state)
          IDLE: if (dwb_stb) begin
            state    <= REQ;
            wdog     <= '0;
            mem_req  <= 1'b1;
            mem_we   <= dwb_wre;
            mem_be   <= dwb_sel;
            mem_adr  <= dwb_adr;
            mem_wdat <= dwb_dto;
          end
          REQ: begin
            wdog <= wdog + 16'd1;
            if (mem_gnt) begin
              mem_req <= 1'b0;
              dwb_ack <= mem_we;
              state   <= mem_we ? ACK : WAIT;
            end
          end
          WAIT: begin
            wdog <= wdog + 16'd1;
            if (mem_rvalid) begin
              dwb_dti <= mem_rdat;
              dwb_ack <= 1'b1;
              state   <= ACK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_t5_dbrg.sv
// tb_t5_dbrg: randomized scoreboard bench for t5_dbrg against a cycle-latency reference model.
module tb_t5_dbrg;
  localparam int TOUT = 8;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        dwb_stb = 1'b0;
  logic        dwb_wre = 1'b0;
  logic [3:0]  dwb_sel = '0;
  logic [29:0] dwb_adr = '0;
  logic [31:0] dwb_dto = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdat = '0;
  logic        dwb_ack, mem_req, mem_we, err_stb;
  logic [31:0] dwb_dti, mem_wdat;
  logic [3:0]  mem_be;
  logic [29:0] mem_adr, err_adr;
  logic [7:0]  err_cnt;

  t5_dbrg #(.TOUT(TOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel), .dwb_adr(dwb_adr), .dwb_dto(dwb_dto),
    .dwb_ack(dwb_ack), .dwb_dti(dwb_dti),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdat(mem_rdat),
    .err_stb(err_stb), .err_adr(err_adr), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] dti;
    logic        err;
    logic [29:0] adr;
    logic [7:0]  ecnt;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_dti = '0;
  int m_ecnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every ack must match the oldest outstanding expectation
  always @(negedge sys_clk) begin : mon
    exp_t e;
    if (!sys_rst) begin
      chk("err_stb_alone", {63'd0, err_stb & ~dwb_ack}, 64'd0);
      if (dwb_ack) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: dwb_ack=1 at cycle %0d, expected no ack", cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.c));
          chk("dwb_dti", {32'd0, dwb_dti}, {32'd0, e.dti});
          chk("err_stb", {63'd0, err_stb}, {63'd0, e.err});
          if (e.err) chk("err_adr", {34'd0, err_adr}, {34'd0, e.adr});
          chk("err_cnt", {56'd0, err_cnt}, {56'd0, e.ecnt});
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge sys_clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ack_missing: %0d acks outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // g: cycles of grant delay after the request appears; r: rvalid cycles after grant
  task automatic run(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                     input logic [31:0] dto, input int g, input int r,
                     input logic [31:0] rdat, input bit stray);
    bit ok;
    int lat;
    int c0;
    exp_t e;
    ok  = we ? (1 + g <= TOUT) : (1 + g + r <= TOUT);
    lat = ok ? (we ? 2 + g : 2 + g + r) : TOUT + 1;
    if (!ok) m_dti = '0;
    else if (!we) m_dti = rdat;
    if (!ok && m_ecnt < 255) m_ecnt++;
    @(negedge sys_clk);
    dwb_stb = 1'b1; dwb_wre = we; dwb_sel = sel; dwb_adr = adr; dwb_dto = dto;
    c0 = cyc + 1;
    e.c = c0 + lat - 1; e.dti = m_dti; e.err = !ok; e.adr = adr; e.ecnt = 8'(m_ecnt);
    sb.push_back(e);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        chk("mem_adr", {34'd0, mem_adr}, {34'd0, adr});
        chk("mem_we", {63'd0, mem_we}, {63'd0, we});
        chk("mem_be", {60'd0, mem_be}, {60'd0, sel});
        chk("mem_wdat", {32'd0, mem_wdat}, {32'd0, dto});
        dwb_stb = 1'b0; dwb_wre = 1'($urandom); dwb_sel = 4'($urandom);
        dwb_adr = 30'($urandom); dwb_dto = $urandom;
      end
      chk("mem_req", {63'd0, mem_req}, {63'd0, (k <= 1 + g && k <= TOUT && k < lat)});
      mem_gnt = (k == 1 + g);
      mem_rvalid = (!we && k == 1 + g + r) || (stray && k <= 1 + g && $urandom_range(1) == 1);
      mem_rdat = (!we && k == 1 + g + r) ? rdat : $urandom;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, {63'd0, dwb_ack}, 64'd0);
    chk({tag, "_dti"}, {32'd0, dwb_dti}, 64'd0);
    chk({tag, "_mem"}, {mem_req, mem_we, mem_be, mem_adr, mem_wdat}, 64'd0);
    chk({tag, "_err"}, {err_stb, err_adr, err_cnt}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    exp_t e;
    repeat (3) @(negedge sys_clk);
    chk_zero("reset");
    sys_rst = 1'b0;
    // read with delayed grant, stray rvalid in REQ
    run(1'b0, 4'hF, 30'h0000_1234, 32'h0, 3, 2, 32'hCAFE_F00D, 1'b1);
    // posted write leaves read data untouched
    run(1'b1, 4'b0011, 30'h40, 32'h1234_5678, 0, 1, 32'h0, 1'b0);
    // unanswered read times out; its response lands late in the ACK cycle
    run(1'b0, 4'hF, 30'h2A5A5, 32'h0, 0, TOUT, 32'hDEAD_BEEF, 1'b0);
    // completion in the final watchdog cycle wins
    run(1'b0, 4'hF, 30'h111, 32'h0, 0, TOUT - 1, 32'h5555_AAAA, 1'b0);
    run(1'b1, 4'h1, 30'h222, 32'h7, TOUT - 1, 1, 32'h0, 1'b0);
    // a read granted in the final cycle still times out
    run(1'b0, 4'h8, 30'h333, 32'h0, TOUT - 1, 1, 32'h9999_9999, 1'b0);
    // back-to-back writes with the strobe held high
    @(negedge sys_clk);
    dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_sel = 4'b0011; dwb_adr = 30'h100; dwb_dto = 32'hA1A1_A1A1;
    mem_gnt = 1'b1;
    c0 = cyc + 1;
    e.c = c0 + 1; e.dti = m_dti; e.err = 1'b0; e.adr = '0; e.ecnt = 8'(m_ecnt);
    sb.push_back(e);
    @(negedge sys_clk);
    chk("b2b_adr_a", {34'd0, mem_adr}, {34'd0, 30'h100});
    chk("b2b_wdat_a", {32'd0, mem_wdat}, {32'd0, 32'hA1A1_A1A1});
    @(negedge sys_clk);
    dwb_sel = 4'b1100; dwb_adr = 30'h200; dwb_dto = 32'hB2B2_B2B2;
    e.c = c0 + 4;
    sb.push_back(e);
    @(negedge sys_clk);
    chk("b2b_idle_req", {63'd0, mem_req}, 64'd0);
    @(negedge sys_clk);
    chk("b2b_req_b", {63'd0, mem_req}, 64'd1);
    chk("b2b_adr_b", {34'd0, mem_adr}, {34'd0, 30'h200});
    chk("b2b_be_b", {60'd0, mem_be}, {60'd0, 4'b1100});
    chk("b2b_wdat_b", {32'd0, mem_wdat}, {32'd0, 32'hB2B2_B2B2});
    @(negedge sys_clk);
    dwb_stb = 1'b0;
    mem_gnt = 1'b0;
    drain();
    // asynchronous reset while waiting for read data
    @(negedge sys_clk);
    dwb_stb = 1'b1; dwb_wre = 1'b0; dwb_sel = 4'hF; dwb_adr = 30'h3FF;
    @(negedge sys_clk);
    dwb_stb = 1'b0;
    mem_gnt = 1'b1;
    @(negedge sys_clk);
    mem_gnt = 1'b0;
    #2 sys_rst = 1'b1;
    #1 chk_zero("async_rst");
    m_dti = '0;
    m_ecnt = 0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdat = 32'h1357_9BDF;
    @(negedge sys_clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("post_rst_no_ack", {63'd0, dwb_ack}, 64'd0);
    end
    run(1'b0, 4'hF, 30'h0ABC, 32'h0, 1, 1, 32'h0F0F_0F0F, 1'b0);
    for (int i = 0; i < 60; i++)
      run(1'($urandom), 4'($urandom), 30'($urandom), $urandom,
          $urandom_range(0, TOUT + 1), $urandom_range(1, TOUT), $urandom, 1'($urandom));
    // drive the error counter into saturation
    for (int i = 0; i < 258; i++)
      run(1'b1, 4'hF, 30'($urandom), $urandom, TOUT, 1, 32'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/t5_dbrg.md
# t5_dbrg

Data-side bus bridge between the `t5_rv32i` core's data port and a request/grant/response memory port (SRAM controller, peripheral fabric).
- Captures each core data strobe into a single outstanding transaction and handles the memory handshake.
- Returns a single-cycle `dwb_ack` to the core; the core's stall logic consumes it.
- A watchdog counter terminates transactions the memory never answers and reports a bus error.

## Interface
Parameters:
- `TOUT`, 256: watchdog limit in cycles spent in REQ+WAIT; legal range 2..65535.

Ports:
- `sys_clk` in 1: clock, rising edge.
- `sys_rst` in 1: reset; asynchronous, active-high.
- `dwb_stb` in 1: core data strobe; held high until `dwb_ack`.
- `dwb_wre` in 1: core write enable.
- `dwb_sel` in 4: core byte lanes.
- `dwb_adr` in 30 [31:2]: core word address.
- `dwb_dto` in 32: core write data.
- `dwb_ack` out 1: transaction done, one-cycle pulse.
- `dwb_dti` out 32: read data, valid while `dwb_ack`=1.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables.
- `mem_adr` out 30 [31:2]: memory word address.
- `mem_wdat` out 32: memory write data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read response valid.
- `mem_rdat` in 32: read response data.
- `err_stb` out 1: one-cycle pulse on timeout.
- `err_adr` out 30 [31:2]: word address of the last timed-out access.
- `err_cnt` out 8: saturating count of timeouts.

## Operation
- FSM states: IDLE, REQ, WAIT, ACK. All outputs are registered.
- Reset values: state=IDLE; all other outputs and internal registers = 0.
- IDLE:
  - `dwb_stb`=1 → latch `dwb_adr/wre/sel/dto` into `mem_adr/we/be/wdat`, clear watchdog, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `mem_req`=1 and the latched fields are held stable.
  - `mem_gnt`=1 with we=1 → ACK.
  - `mem_gnt`=1 with we=0 → WAIT.
  - `mem_rvalid` is ignored in REQ.
- WAIT:
  - `mem_req`=0.
  - `mem_rvalid`=1 → capture `mem_rdat` into `dwb_dti`, go to ACK.
- ACK:
  - `dwb_ack`=1 for exactly one cycle, then IDLE.
  - `dwb_dti` holds its value until the next capture.
- Writes are posted: they complete on grant. Write acks leave `dwb_dti` unchanged.
- Watchdog:
  - 16-bit counter; increments every cycle in REQ or WAIT.
  - When the counter equals `TOUT-1` and no completion occurs that cycle:
    - go to ACK with `dwb_dti`=0;
    - `err_stb`=1 for that cycle;
    - `err_adr`←`mem_adr`;
    - `err_cnt`←`err_cnt`+1, saturating at 255.
- Completion vs timeout in the same cycle: completion wins, no error.
- `dwb_stb` is sampled only in IDLE. If the core drops the strobe mid-transaction, the latched transaction still completes and is still acked.
- `mem_rvalid` arriving outside WAIT, including a late response after a timeout, is discarded. The memory port guarantees it never responds more than `TOUT` cycles after grant.
- Asynchronous reset mid-transaction: everything returns to reset values at once. Any in-flight memory transaction is abandoned; no ack is issued.

## Timing
- The request is visible on `mem_*` one cycle after `dwb_stb` is sampled in IDLE.
- Write with immediate grant: strobe sampled at edge 0; `mem_req`=1 in cycle 1; gnt in cycle 1; `dwb_ack` in cycle 2. Minimum 3 cycles from strobe to ack.
- Read with gnt in cycle 1 and rvalid in cycle 2: `dwb_ack` with data in cycle 3.
- Each cycle of gnt or rvalid delay adds one cycle of latency.
- Back-to-back: after the ACK cycle the FSM is in IDLE. If `dwb_stb` is still high there, it is treated as a new transaction (the core has advanced). Maximum throughput is one write per 3 cycles.
- Timeout ack occurs at cycle 1+`TOUT` after the strobe is sampled: `TOUT` cycles in REQ/WAIT, then the ACK cycle.
- `mem_req` never stays high in the cycle after `mem_gnt`.

## Test plan
- Reset check: assert `sys_rst` asynchronously mid-cycle → all outputs read 0 immediately; state is IDLE.
- Write path: write adr=0x0000_0100>>2, sel=4'b0011, dto=0x1234_5678, gnt in cycle 1 → `mem_be`=0011, `mem_wdat`=0x12345678, `dwb_ack` in cycle 2 only; `dwb_dti` unchanged.
- Read path: read with gnt delayed 3 cycles and rvalid 2 cycles after gnt, rdat=0xCAFE_F00D → `dwb_ack` exactly once with `dwb_dti`=0xCAFEF00D. A stray rvalid injected during REQ is ignored.
- Timeout: TOUT=4, read never answered → ack at cycle 5 with `dwb_dti`=0; `err_stb` pulses; `err_adr` = latched address; `err_cnt`=1. A late rvalid afterward produces no ack.
- Timeout race: rvalid arrives exactly in the cycle where the counter equals `TOUT-1` → normal ack with data; no `err_stb`; `err_cnt` unchanged.
- Back-to-back and reset: stb held high across two writes → two acks 3 cycles apart with correct per-transaction fields. Assert reset while in WAIT → no ack; the next transaction after reset works normally.
